// File: rtl/jamma_joy_scan_if.sv
// Signal bundle between the JAMMA connector/keyboard side and the control scanner.
interface jamma_joy_scan_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int JOY_W       = 8
);
    localparam int SEL_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;

    // No valid/ready pair: jjoy is only qualified by the scanner's own SAMPLE tick while
    // jsel points at a player, joy_out is valid every cycle, scan_done is a 1-cycle strobe.
    logic [JOY_W-1:0]             jjoy;
    logic [NUM_PLAYERS*JOY_W-1:0] kb_press;
    logic [SEL_W-1:0]             jsel;
    logic [NUM_PLAYERS*JOY_W-1:0] joy_out;
    logic                         scan_done;
    logic                         scan_state;  // 1 while the scan FSM sits in SAMPLE

    modport master (
        output jjoy, kb_press,
        input  jsel, joy_out, scan_done, scan_state
    );

    modport slave (
        input  jjoy, kb_press,
        output jsel, joy_out, scan_done, scan_state
    );
endinterface

// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA joystick scanner: select, settle, sample, per-bit debounce,
// keyboard overlay and one registered active-low control word per player.
module jamma_joy_scan #(
    parameter int NUM_PLAYERS = 2,
    parameter int JOY_W       = 8,
    parameter int SETTLE      = 1,
    parameter int DEBOUNCE    = 2
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ena,
    jamma_joy_scan_if.slave bus
);
    localparam int             SEL_W       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
    localparam int             TOT_W       = NUM_PLAYERS * JOY_W;
    localparam logic [7:0]     SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
    localparam logic [3:0]     DB_LAST     = 4'(DEBOUNCE - 1);
    localparam logic [SEL_W-1:0] P_LAST    = SEL_W'(NUM_PLAYERS - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } state_e;

    // With no settle time every tick is a sample, so the FSM parks in SAMPLE.
    localparam state_e ST_RESET = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_e                                   state_q, state_d;
    logic [7:0]                               cnt_q, cnt_d;
    logic [SEL_W-1:0]                         p_q, p_d;
    logic [NUM_PLAYERS-1:0][JOY_W-1:0]        stable_q, stable_d;
    logic [NUM_PLAYERS-1:0][JOY_W-1:0][3:0]   dbc_q, dbc_d;
    logic [TOT_W-1:0]                         joy_q;
    logic [TOT_W-1:0]                         stable_flat;
    logic                                     do_sample;

    assign stable_flat = stable_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        do_sample = 1'b0;
        if (ena) begin
            case (state_q)
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    do_sample = 1'b1;
                    p_d       = (p_q == P_LAST) ? '0 : p_q + 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            endcase
        end
    end

    // Only the player currently on the connector has its debounce state touched.
    always_comb begin
        stable_d = stable_q;
        dbc_d    = dbc_q;
        if (do_sample) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (p_q == SEL_W'(p)) begin
                    for (int j = 0; j < JOY_W; j++) begin
                        if (bus.jjoy[j] == stable_q[p][j]) begin
                            dbc_d[p][j] = 4'd0;
                        end else if (dbc_q[p][j] == DB_LAST) begin
                            stable_d[p][j] = bus.jjoy[j];
                            dbc_d[p][j]    = 4'd0;
                        end else begin
                            dbc_d[p][j] = dbc_q[p][j] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_RESET;
            cnt_q    <= 8'd0;
            p_q      <= '0;
            stable_q <= '1;
            dbc_q    <= '0;
            joy_q    <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            stable_q <= stable_d;
            dbc_q    <= dbc_d;
            joy_q    <= stable_flat & ~bus.kb_press;
        end
    end

    assign bus.jsel       = p_q;
    assign bus.joy_out    = joy_q;
    assign bus.scan_done  = do_sample && (p_q == P_LAST) && !reset;
    assign bus.scan_state = (state_q == ST_SAMPLE);
endmodule

// File: doc/jamma_joy_scan.md
Name: jamma_joy_scan

Overview:
- Time-multiplexed JAMMA control scanner for the ZX-UNO arcade tops.
- Drives the external select line(s) and waits a settle time after each select change.
- Samples the shared active-low joystick bus, debounces every bit per player, merges the keyboard overrides, and presents one registered active-low control word per player to the game core.
- Generalises the fixed two-player toggle to N players, with configurable settle time and debounce depth.

Parameters:
NUM_PLAYERS, 2, players on the shared bus (2..8); SEL_W = max(1, clog2(NUM_PLAYERS))
JOY_W, 8, bits per player word (bit0 up, 1 down, 2 left, 3 right, 4 fire, 7 start)
SETTLE, 1, ena ticks to wait after a select change before sampling (0..255)
DEBOUNCE, 2, consecutive differing samples required to change a stable bit (1..15)

Ports:
clk_sys  in  1  system clock (24 MHz domain)
reset  in  1  synchronous, active-high reset
ena  in  1  scan clock-enable tick; the FSM advances only when ena=1
jjoy  in  JOY_W  shared JAMMA bus, active-low (0 = pressed)
kb_press  in  NUM_PLAYERS*JOY_W  keyboard overlay, active-high; player p occupies bits [p*JOY_W +: JOY_W]
jsel  out  SEL_W  binary index of the player currently selected on the connector
joy_out  out  NUM_PLAYERS*JOY_W  debounced, merged controls, active-low, same packing as kb_press
scan_done  out  1  one clk_sys pulse when the last player has been sampled

Behaviour:
- Reset (synchronous, active-high, on clk_sys):
  - jsel=0, state=SETTLE, settle counter=0, player index=0.
  - All stable bits=1 (released); all debounce counters=0; joy_out=all 1s; scan_done=0.
  - Reset asserted mid-scan aborts the scan immediately; no partial sample is retained.
- FSM: two states, SETTLE and SAMPLE. Nothing advances on cycles with ena=0; scan_done is 0 on those cycles.
- SETTLE, on an ena tick:
  - if cnt==SETTLE-1, go to SAMPLE;
  - otherwise cnt++.
  - With SETTLE=0 the SETTLE state is bypassed: every ena tick is a SAMPLE.
- SAMPLE, on an ena tick:
  - capture jjoy as raw[p] and run the debounce update for player p;
  - p <= (p==NUM_PLAYERS-1) ? 0 : p+1, and jsel takes the new p in the same clk_sys edge;
  - cnt<=0; state=SETTLE (or stays SAMPLE when SETTLE=0);
  - scan_done=1 for this one cycle if the old p was NUM_PLAYERS-1.
- Scan timing:
  - per-player period = SETTLE+1 ena ticks;
  - full scan = NUM_PLAYERS*(SETTLE+1) ena ticks;
  - jsel stays constant from the select change through the sample edge.
- Debounce, per bit, evaluated only in SAMPLE for player p:
  - if raw==stable: count<=0;
  - else if count==DEBOUNCE-1: stable<=raw and count<=0;
  - else count++.
  - With DEBOUNCE=1, every sample is taken directly. The counter is 4 bits and never wraps.
- Output: joy_out <= stable & ~kb_press, registered every clk_sys cycle regardless of ena. Latency is 1 clk_sys cycle from a stable-bit change or a kb_press change.
- Other players' stable bits and counters are untouched during player p's sample.
- If jjoy changes during SETTLE it is ignored; only the value at the SAMPLE edge counts.

Test Plan:
- Reset with NUM_PLAYERS=2, SETTLE=1, ena=1 held -> jsel=0, joy_out=16'hFFFF, scan_done=0. The first sample is at the 2nd ena tick; jsel then reads 1,1,0,0… changing every 2 cycles; scan_done pulses on every 4th cycle.
- DEBOUNCE=3, player 0, jjoy=8'hFE for exactly 2 player-0 samples, then 8'hFF -> joy_out[7:0] stays 8'hFF. Holding 8'hFE for 3 player-0 samples -> joy_out[7:0]=8'hFE one cycle after the 3rd sample edge.
- kb_press[8+7]=1 (player 1 start) with all joysticks released -> joy_out[15]=0 after 1 clk_sys cycle, independent of ena and scan position. Deasserting it -> joy_out[15]=1.
- ena toggling 1-of-4 cycles, SETTLE=2 -> jsel changes every 12 clk_sys cycles and scan_done is 1 clk_sys wide. Injecting a jjoy glitch during SETTLE leaves the stable state unchanged.
- NUM_PLAYERS=4, SETTLE=0, jjoy driven per jsel value (8'hF0|jsel) -> jsel sequence 0,1,2,3,0 on successive ticks, scan_done on the 3→0 wrap. After DEBOUNCE scans, joy_out = {8'hF3,8'hF2,8'hF1,8'hF0}.
- Assert reset while jsel=1 with player 0 pressed and debounce counts nonzero -> next cycle jsel=0, joy_out all 1s. After release, the press needs the full DEBOUNCE samples again.
